window_reg_kxk_stream: RTL
==========================

Name: window_reg_kxk_stream

Overview:
Parametrised successor of the fixed 3x3 window register used by the Conv2d datapath. It accepts a raster-order pixel stream over a valid/ready handshake, builds rows internally with K-1 line buffers, and presents a KxK window with valid/ready backpressure. It supports configurable stride, window position tags and end-of-frame marking, and sits between the feature-map reader and the MAC array.

Parameters:
DATA_WIDTH, 16, pixel width in bits
K, 3, window size (KxK); legal range K >= 2
IMG_WIDTH, 8, pixels per row; must satisfy IMG_WIDTH >= K
IMG_HEIGHT, 8, rows per frame; must satisfy IMG_HEIGHT >= K
STRIDE, 1, window stride in both directions; legal range 1..K

Ports:
clk  in  1  clock; all state changes on the rising edge
Rst_window  in  1  asynchronous, active-low reset
Clr_frame  in  1  synchronous frame restart; active-high
in_pixel  in  DATA_WIDTH  input pixel
in_valid  in  1  in_pixel is valid
in_ready  out  1  block accepts in_pixel this cycle
out_window  out  K*K*DATA_WIDTH  window; element [r][c] occupies bits [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]
out_valid  out  1  out_window is a complete, stride-aligned window
out_ready  in  1  consumer accepts the window
out_row  out  clog2(IMG_HEIGHT)  input row of window element [K-1][0]
out_col  out  clog2(IMG_WIDTH)  input column of window element [K-1][0]
out_last  out  1  last window of the frame; qualified by out_valid

Behaviour:
- Accept: acc = in_valid && in_ready. in_ready = !(out_valid && !out_ready), so input and output may move in the same cycle.
- Window orientation: row K-1 is the newest row and row 0 the oldest. Column 0 is the newest pixel, and the window shifts right (column c moves to c+1).
- On acc:
  - window column 0 loads {line buffer K-2 output, ..., line buffer 0 output, in_pixel}, rows 0..K-1;
  - columns 1..K-1 shift right;
  - line buffer 0 takes in_pixel; line buffer i takes the output of buffer i-1.
- With no acc, the window and line buffers hold.
- Counters col_cnt (0..IMG_WIDTH-1) and row_cnt (0..IMG_HEIGHT-1) index the pixel being accepted:
  - col_cnt wraps at IMG_WIDTH-1 and row_cnt increments;
  - after pixel (H-1, W-1), both wrap to 0 and the next frame begins.
- Phase counters track the column offset col_cnt-(K-1) and the row offset row_cnt-(K-1), each mod STRIDE. No divider is used.
- Window emission: emit = acc && row_cnt >= K-1 && col_cnt >= K-1 && col phase == 0 && row phase == 0.
- out_valid is registered, latency 1: it is set the cycle after an emitting acc.
  - It clears on out_ready unless a new emit occurs in the same cycle.
  - out_row/out_col/out_last are registered with out_valid; out_last = emit at (H-1, W-1).
- Column wrap: windows with col_cnt < K-1 straddle two rows and are never emitted. Stale line-buffer data from the previous frame is never emitted, because row_cnt gates emission.
- Window count per frame: ((IMG_HEIGHT-K)/STRIDE+1) * ((IMG_WIDTH-K)/STRIDE+1), using integer division.
- FSM states:
  - FILL: row_cnt < K-1, no emission. Moves to RUN on accepting pixel (K-1, 0).
  - RUN: emission enabled. Moves to DRAIN on accepting the last pixel.
  - DRAIN: final window pending, in_ready = 0. Moves to FILL on out_ready or Clr_frame.
- Reset: on Rst_window low, asynchronously and immediately:
  - window registers, line buffers, counters and phases go to 0;
  - FSM goes to FILL;
  - out_valid = 0, out_last = 0, out_row = 0, out_col = 0;
  - in_ready = 1 after release.
- Clr_frame takes priority over acc in the same cycle. It clears counters, phases, out_valid and out_last, and sets the FSM to FILL. Window and line-buffer contents are left untouched, and the pixel presented in that cycle is not accepted.
- Stability: while out_valid && !out_ready, out_window, out_row, out_col and out_last are held constant.

Decomposition:
- Package window_pkg holds:
  - index functions: clog2, and win_idx(r,c) = (r*K+c);
  - FSM state encoding {FILL, RUN, DRAIN};
  - legality checks on the parameters, done as elaboration-time assertions.
- Sub-module line_buffer (DATA_WIDTH, DEPTH = IMG_WIDTH): an enable-gated shift register or circular RAM with a registered read. It is instantiated K-1 times and chained. Its output is the pixel exactly IMG_WIDTH accepts earlier.

Test Plan:
Defaults (K=3, 8x8, STRIDE=1); in_pixel = row*8+col; out_ready held 1; in_valid held 1 -> first out_valid the cycle after the 19th accept; window [2][0]=18, [2][2]=16, [0][0]=2, [0][2]=0; out_row=2, out_col=2.
Same stream -> exactly 36 windows; the last has out_last=1, [2][0]=63, [0][2]=45; FSM enters DRAIN, then FILL.
STRIDE=2 -> 9 windows at (row, col) in {2,4,6}x{2,4,6}; none at odd offsets; out_last on (6,6).
Drop out_ready for 5 cycles while out_valid=1 -> in_ready=0; out_window and out_row/out_col stay constant; no pixel lost; after release, window sequence and count identical to scenario 1.
Random in_valid gaps (~30%) -> same 36 windows in the same order with the same contents.
Pull Rst_window low mid-row 4 -> out_valid=0 immediately; restart a full frame -> identical output to scenario 1. Assert Clr_frame mid-frame -> same restart result; the pixel presented with Clr_frame is not counted.

Source files
------------

// File: rtl/window_pkg.sv
// Shared types and elaboration helpers for the KxK streaming window register.
package window_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } win_state_e;

    // Ceiling log2 with a floor of 1 so single-value counters still get a bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        longint unsigned x;
        r = 0;
        x = 1;
        while (x < longint'(v)) begin
            x = x << 1;
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                            input int unsigned k);
        return r * k + c;
    endfunction

    function automatic bit params_ok(input int unsigned k, input int unsigned w,
                                     input int unsigned h, input int unsigned s);
        return (k >= 2) && (w >= k) && (h >= k) && (s >= 1) && (s <= k);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Enable-gated pixel delay line; dout is the pixel DEPTH accepts earlier.
module line_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            mem[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/window_reg_kxk_stream.sv
// Raster-stream to KxK sliding window with stride, position tags and frame-end marking.
module window_reg_kxk_stream
    import window_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned K          = 3,
    parameter int unsigned IMG_WIDTH  = 8,
    parameter int unsigned IMG_HEIGHT = 8,
    parameter int unsigned STRIDE     = 1
) (
    input  logic                          clk,
    input  logic                          Rst_window,
    input  logic                          Clr_frame,
    input  logic [DATA_WIDTH-1:0]         in_pixel,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [K*K*DATA_WIDTH-1:0]     out_window,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [clog2(IMG_HEIGHT)-1:0]  out_row,
    output logic [clog2(IMG_WIDTH)-1:0]   out_col,
    output logic                          out_last
);

    localparam int unsigned ROW_W       = clog2(IMG_HEIGHT);
    localparam int unsigned COL_W       = clog2(IMG_WIDTH);
    localparam int unsigned PH_W        = clog2(STRIDE);
    localparam int unsigned WIN_W       = K * K * DATA_WIDTH;
    localparam int unsigned LAST_ROW    = K - 1 + ((IMG_HEIGHT - K) / STRIDE) * STRIDE;
    localparam int unsigned LAST_COL    = K - 1 + ((IMG_WIDTH - K) / STRIDE) * STRIDE;
    localparam int unsigned PH_EMIT     = (K - 1) % STRIDE;

    if (!params_ok(K, IMG_WIDTH, IMG_HEIGHT, STRIDE)) begin : g_bad_params
        $error("window_reg_kxk_stream: illegal K/IMG_WIDTH/IMG_HEIGHT/STRIDE combination");
    end

    win_state_e              state_q, state_d;
    logic [COL_W-1:0]        col_cnt;
    logic [ROW_W-1:0]        row_cnt;
    logic [PH_W-1:0]         col_ph;
    logic [PH_W-1:0]         row_ph;
    logic [WIN_W-1:0]        win_q;
    logic [DATA_WIDTH-1:0]   lb_din [K-1];
    logic [DATA_WIDTH-1:0]   lb_out [K-1];
    logic [DATA_WIDTH-1:0]   col_in [K];
    logic                    acc;
    logic                    emit;
    logic                    col_wrap;
    logic                    row_wrap;
    logic                    last_win;

    // Clear wins over a same-cycle handshake, so the presented pixel is refused.
    assign in_ready = !(out_valid && !out_ready) && (state_q != DRAIN) && !Clr_frame;
    assign acc      = in_valid && in_ready;
    assign col_wrap = (col_cnt == COL_W'(IMG_WIDTH - 1));
    assign row_wrap = (row_cnt == ROW_W'(IMG_HEIGHT - 1));
    assign last_win = (row_cnt == ROW_W'(LAST_ROW)) && (col_cnt == COL_W'(LAST_COL));
    // Phases count col/row mod STRIDE from zero; alignment is where they equal (K-1) mod STRIDE.
    assign emit     = acc && (state_q == RUN)
                   && (row_cnt >= ROW_W'(K - 1)) && (col_cnt >= COL_W'(K - 1))
                   && (col_ph == PH_W'(PH_EMIT)) && (row_ph == PH_W'(PH_EMIT));

    for (genvar i = 0; i < K - 1; i++) begin : g_lb
        if (i == 0) begin : g_head
            assign lb_din[i] = in_pixel;
        end else begin : g_chain
            assign lb_din[i] = lb_out[i-1];
        end

        line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_WIDTH)
        ) u_lb (
            .clk   (clk),
            .rst_n (Rst_window),
            .en    (acc),
            .din   (lb_din[i]),
            .dout  (lb_out[i])
        );

        assign col_in[K-2-i] = lb_out[i];
    end
    assign col_in[K-1] = in_pixel;

    // Newest column enters at c=0 and older columns move toward c=K-1.
    always_ff @(posedge clk or negedge Rst_window) begin
        if (!Rst_window) begin
            win_q <= '0;
        end else if (acc) begin
            for (int unsigned r = 0; r < K; r++) begin
                win_q[win_idx(r, 0, K)*DATA_WIDTH +: DATA_WIDTH] <= col_in[r];
                for (int unsigned c = 1; c < K; c++) begin
                    win_q[win_idx(r, c, K)*DATA_WIDTH +: DATA_WIDTH] <=
                        win_q[win_idx(r, c - 1, K)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign out_window = win_q;

    always_ff @(posedge clk or negedge Rst_window) begin
        if (!Rst_window) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            col_ph    <= '0;
            row_ph    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
        end else if (Clr_frame) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            col_ph    <= '0;
            row_ph    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (acc) begin
                if (col_wrap) begin
                    col_cnt <= '0;
                    col_ph  <= '0;
                    row_cnt <= row_wrap ? '0 : row_cnt + 1'b1;
                    row_ph  <= (row_wrap || (row_ph == PH_W'(STRIDE - 1))) ? '0 : row_ph + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                    col_ph  <= (col_ph == PH_W'(STRIDE - 1)) ? '0 : col_ph + 1'b1;
                end
            end
            if (emit) begin
                out_valid <= 1'b1;
                out_row   <= row_cnt;
                out_col   <= col_cnt;
                out_last  <= last_win;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge Rst_window) begin
        if (!Rst_window) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (Clr_frame) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL: begin
                    if (acc && (row_cnt == ROW_W'(K - 1)) && (col_cnt == '0)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (acc && col_wrap && row_wrap) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

endmodule
